rvc_asap_5pl_vga_rx: RTL
========================

# rvc_asap_5pl_vga_rx

VGA capture receiver for the rvc_asap_5pl platform. It consumes the RED/GREEN/BLUE/h_sync/v_sync stream that `rvc_top_5pl` drives and recovers pixel coordinates from the sync pulses. It reduces each pixel to one lit/unlit bit and writes the result as a bit-packed 640x480 frame through a byte write port, in the same layout as the VGA memory (38400 bytes). It provides a hardware end-to-end check of the VGA path, for bench or FPGA loopback.

## Interface
Parameters:
- CLK_PER_PIX, 2: Clock cycles per pixel (50 MHz Clock, 25 MHz pixel rate).
- H_TOTAL, 800: pixels per line.
- H_START, 144: first visible pixel, counted from the h_sync falling edge (sync 96 + back porch 48).
- H_VIS, 640: visible pixels per line.
- V_START, 35: first visible line, counted from the v_sync falling edge (sync 2 + back porch 33).
- V_VIS, 480: visible lines.

Ports:
- Clock, in, 1: single clock. It is the same clock that drives the VGA source.
- Rst_N, in, 1: asynchronous assert, active-low reset.
- Capture_En, in, 1: while high, capture frames continuously.
- RED, in, 4: red channel.
- GREEN, in, 4: green channel.
- BLUE, in, 4: blue channel.
- h_sync, in, 1: horizontal sync, active-low.
- v_sync, in, 1: vertical sync, active-low.
- Wr_En, out, 1: one-cycle byte write strobe.
- Wr_Addr, out, 16: byte address in the range 0..38399.
- Wr_Data, out, 8: 8 packed pixels.
- Frame_Done, out, 1: one-cycle pulse after the last byte of a frame is written.
- Frame_Cnt, out, 8: completed frames, wraps 255 to 0.
- Locked, out, 1: timing has been verified for one full line.
- Sync_Err, out, 1: sticky line-length error. Cleared on the next v_sync fall.

## Operation
- Input registering: all video inputs are registered once. All edge detection and sampling uses the registered copies.
- h_sync fall (registered value 0, previous value 1):
  - phase counter is set to 0 and hcnt is set to 0;
  - vcnt increments;
  - the line-length check runs.
- Pixel counting:
  - phase counts 0..CLK_PER_PIX-1;
  - hcnt increments when phase wraps;
  - the pixel is sampled at phase 0.
- v_sync fall: vcnt is set to 0. If it occurs in the same cycle as an h_sync fall, v_sync wins and vcnt is 0.
- Visible window: hcnt in [H_START, H_START+H_VIS-1] and vcnt in [V_START, V_START+V_VIS-1].
  - x = hcnt-H_START
  - y = vcnt-V_START
- Pixel bit: lit = (RED|GREEN|BLUE) != 0. It is shifted into byte bit position x[2:0], so bit 0 is the leftmost pixel.
- Byte write: when x[2:0]==7, the packed byte is written.
  - Wr_Addr = (y>>2)*320 + (x>>3)*4 + y[1:0]
  - Wr_Data is the packed byte.
- State machine:
  - IDLE: outputs are quiet. Go to WAIT_VS when Capture_En=1 and Locked=1.
  - WAIT_VS: wait for a v_sync fall, then go to CAPTURE. A capture never starts mid-frame.
  - CAPTURE: write bytes in the visible window. After the write for y=479, x=639, pulse Frame_Done, increment Frame_Cnt, and go to WAIT_VS if Capture_En=1, otherwise IDLE.
  - Any state goes to IDLE when Locked drops.
- Capture_En deasserted mid-frame: the current frame completes. The block then goes to IDLE.
- Lock and errors:
  - Locked sets on an h_sync fall where the previous line measured exactly H_TOTAL pixels (hcnt==H_TOTAL-1 with phase==CLK_PER_PIX-1 at the fall).
  - A mismatch at an h_sync fall, or hcnt reaching H_TOTAL with no fall, sets Sync_Err and clears Locked.
  - A CAPTURE frame that sees a Sync_Err does not pulse Frame_Done, and Frame_Cnt does not increment.
- Counter widths and saturation:
  - hcnt is 10 bits and saturates at 1023.
  - vcnt is 10 bits and saturates at 1023.

## Timing
- Reset values: Wr_En=0, Wr_Addr=0, Wr_Data=0, Frame_Done=0, Frame_Cnt=0, Locked=0, Sync_Err=0. All counters are 0 and the state is IDLE.
- Input-to-write latency: Wr_En asserts 2 Clock cycles after the source Clock edge that drives the pixel with x[2:0]==7. Path is input register, then sample, then write register.
- Frame_Done asserts the cycle after the final Wr_En. It is never coincident with Wr_En.
- Write rate: one Wr_En per 8*CLK_PER_PIX cycles inside the visible window. There are exactly 38400 writes per good frame, with strictly increasing addresses per row group.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). After release, the block must re-lock before capturing.

## Test plan
- Nominal frame: drive 640x480 timing with all pixels lit. Require 38400 writes, all Wr_Data=8'hFF, one Frame_Done, and Frame_Cnt=1.
- Single pixel at (x=9, y=5), all others black. Require exactly one nonzero write: Wr_Addr=325, Wr_Data=8'h02.
- Short line (799 pixels) injected on line 100. Require Sync_Err=1 and Locked=0, with no Frame_Done for that frame. Sync_Err clears at the next v_sync fall, and capture resumes after re-lock.
- Capture_En raised at line 200 of a frame. Require no writes until the next v_sync fall, then a full frame.
- Simultaneous v_sync fall and h_sync fall. Require vcnt=0, and the first visible row written at y=0 (Wr_Addr 0..316 step 4 for byte row 0).
- Rst_N pulsed low mid-CAPTURE. Require immediate Wr_En=0, Locked=0, Frame_Cnt=0, and correct recovery on a subsequent frame.

Source files
------------

// File: rtl/rvc_asap_5pl_vga_rx.sv
// VGA capture receiver: recovers pixel coordinates from the sync pulses and writes
// a bit-packed monochrome frame (8 pixels per byte) through a byte write port.
`timescale 1ns/1ps
module rvc_asap_5pl_vga_rx #(
    parameter int CLK_PER_PIX = 2,
    parameter int H_TOTAL     = 800,
    parameter int H_START     = 144,
    parameter int H_VIS       = 640,
    parameter int V_START     = 35,
    parameter int V_VIS       = 480
) (
    input  logic        Clock,
    input  logic        Rst_N,
    input  logic        Capture_En,
    input  logic [3:0]  RED,
    input  logic [3:0]  GREEN,
    input  logic [3:0]  BLUE,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic        Wr_En,
    output logic [15:0] Wr_Addr,
    output logic [7:0]  Wr_Data,
    output logic        Frame_Done,
    output logic [7:0]  Frame_Cnt,
    output logic        Locked,
    output logic        Sync_Err
);

    localparam int PW = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_PER_PIX - 1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [9:0]    CNT_MAX  = 10'd1023;
    localparam logic [9:0]    H_TOT_W  = 10'(H_TOTAL);
    localparam logic [9:0]    H_LO     = 10'(H_START);
    localparam logic [9:0]    H_HI     = 10'(H_START + H_VIS - 1);
    localparam logic [9:0]    V_LO     = 10'(V_START);
    localparam logic [9:0]    V_HI     = 10'(V_START + V_VIS - 1);
    localparam logic [9:0]    X_LAST   = 10'(H_VIS - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_VIS - 1);
    localparam logic [15:0]   ROW_GRP  = 16'(H_VIS / 2);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t          state, state_next;
    logic [3:0]      red_q, green_q, blue_q;
    logic            hs_q, vs_q, hs_prev, vs_prev;
    logic            hs_fall, vs_fall;
    logic [PW-1:0]   phase, cur_phase;
    logic [9:0]      hcnt, vcnt, cur_hcnt, cur_vcnt;
    logic            seen_hs, len_ok, mismatch, overrun;
    logic            phase_wrap, in_window, take, write, is_last, lit;
    logic [9:0]      x, y;
    logic [7:0]      pix_byte, byte_next;
    logic [15:0]     addr_next;
    logic            last_pend;

    // Sync registers reset low so a release mid-pulse never fakes a falling edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            red_q   <= RED;
            green_q <= GREEN;
            blue_q  <= BLUE;
            hs_q    <= h_sync;
            vs_q    <= v_sync;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
        end
    end

    assign hs_fall = !hs_q && hs_prev;
    assign vs_fall = !vs_q && vs_prev;

    // cur_* is the position of the pixel currently in the input register; the fall
    // cycle itself is pixel 0, phase 0 of the new line.
    assign cur_phase  = hs_fall ? '0 : phase;
    assign cur_hcnt   = hs_fall ? '0 : hcnt;
    assign phase_wrap = (cur_phase == PH_LAST);

    always_comb begin
        cur_vcnt = vcnt;
        if (vs_fall)
            cur_vcnt = '0;
        else if (hs_fall && vcnt != CNT_MAX)
            cur_vcnt = vcnt + 10'd1;
    end

    // The registered counters already point one step past the last pixel, so a
    // line of exactly H_TOTAL pixels shows hcnt==H_TOTAL, phase==0 at the next fall.
    assign len_ok   = (hcnt == H_TOT_W) && (phase == '0);
    assign mismatch = seen_hs && hs_fall && !len_ok;
    assign overrun  = seen_hs && !hs_fall && len_ok;

    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            phase   <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
            seen_hs <= 1'b0;
        end else begin
            phase   <= phase_wrap ? '0 : cur_phase + PH_ONE;
            hcnt    <= (phase_wrap && cur_hcnt != CNT_MAX) ? cur_hcnt + 10'd1 : cur_hcnt;
            vcnt    <= cur_vcnt;
            seen_hs <= seen_hs | hs_fall;
        end
    end

    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            Locked   <= 1'b0;
            Sync_Err <= 1'b0;
        end else if (mismatch || overrun) begin
            Locked   <= 1'b0;
            Sync_Err <= 1'b1;
        end else begin
            if (hs_fall && seen_hs)
                Locked <= 1'b1;
            if (vs_fall)
                Sync_Err <= 1'b0;
        end
    end

    assign in_window = (cur_hcnt >= H_LO) && (cur_hcnt <= H_HI) &&
                       (cur_vcnt >= V_LO) && (cur_vcnt <= V_HI);
    assign x         = cur_hcnt - H_LO;
    assign y         = cur_vcnt - V_LO;
    assign lit       = |{red_q, green_q, blue_q};
    assign take      = (cur_phase == '0) && in_window;
    assign write     = take && (x[2:0] == 3'd7) && (state == CAPTURE);
    assign is_last   = (x == X_LAST) && (y == Y_LAST);
    assign addr_next = 16'(y[9:2]) * ROW_GRP + 16'({x[9:3], 2'b00}) + 16'(y[1:0]);

    // NOTE: always_comb assigns a default before any conditional update, so no latch is inferred.
    always_comb begin
        byte_next         = pix_byte;
        byte_next[x[2:0]] = lit;
    end

    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            pix_byte   <= '0;
            Wr_En      <= 1'b0;
            Wr_Addr    <= '0;
            Wr_Data    <= '0;
            last_pend  <= 1'b0;
            Frame_Done <= 1'b0;
            Frame_Cnt  <= '0;
        end else begin
            if (take)
                pix_byte <= byte_next;
            Wr_En <= write;
            if (write) begin
                Wr_Addr <= addr_next;
                Wr_Data <= byte_next;
            end
            // A frame that saw a sync error is not counted as completed.
            last_pend  <= write && is_last && !Sync_Err;
            Frame_Done <= last_pend;
            if (last_pend)
                Frame_Cnt <= Frame_Cnt + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Capture_En && Locked) state_next = WAIT_VS;
            WAIT_VS: if (!Capture_En)          state_next = IDLE;
                     else if (vs_fall)         state_next = CAPTURE;
            CAPTURE: if (write && is_last)     state_next = Capture_En ? WAIT_VS : IDLE;
            default:                           state_next = IDLE;
        endcase
        if (!Locked)
            state_next = IDLE;
    end

endmodule
